cci_mpf_shim_lockstep_deq_sched: RTL and testbench



---
 rtl/cci_mpf_shim_lockstep_sched_pkg.sv | 17 +
 rtl/cci_mpf_prim_credit_counter.sv | 38 +++
 rtl/cci_mpf_shim_lockstep_deq_sched.sv | 108 ++++++++++
 tb/tb_cci_mpf_shim_lockstep_deq_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_shim_lockstep_sched_pkg.sv
// Shared types for the lockstep Tx dequeue scheduler.
// Scheduler states and counter-width helper.
package cci_mpf_shim_lockstep_sched_pkg;

  typedef enum logic [1:0] {
    RUN,
    INTR_WAIT,
    DRAIN
  } t_lockstep_sched_state;

  localparam int SCHED_MAX_OUT_LIMIT = 255;

  function automatic int cnt_bits(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/cci_mpf_prim_credit_counter.sv
// Outstanding-request counter with a hard limit.
// Saturates at 0 and LIMIT and flags a sticky underflow.
module cci_mpf_prim_credit_counter #(
  parameter int LIMIT = 64,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  assign full = (count >= LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      unique case (1'b1)
        inc && !dec: begin
          if (!full) count <= count + 1'b1;
        end
        dec && !inc: begin
          if (count == '0) underflow <= 1'b1;
          else             count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cci_mpf_shim_lockstep_deq_sched.sv
// Lockstep Tx buffer dequeue scheduler.
// Releases a whole head only when every valid part can issue.
module cci_mpf_shim_lockstep_deq_sched
  import cci_mpf_shim_lockstep_sched_pkg::*;
#(
  parameter int MAX_RD_OUT = 64,
  parameter int MAX_WR_OUT = 64,
  parameter int CNT_BITS   = cnt_bits(MAX_RD_OUT, MAX_WR_OUT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                head_notEmpty,
  input  logic                head_rdValid,
  input  logic                head_wrValid,
  input  logic                head_intrValid,
  input  logic                c0TxAlmFull,
  input  logic                c1TxAlmFull,
  input  logic                c0_rsp_valid,
  input  logic                c1_rsp_valid,
  input  logic                drain_req,
  output logic                deqTx,
  output logic                drain_done,
  output logic [CNT_BITS-1:0] rd_outstanding,
  output logic [CNT_BITS-1:0] wr_outstanding,
  output logic                err_underflow
);

  t_lockstep_sched_state state, state_next;

  logic rd_full, wr_full;
  logic rd_uf, wr_uf;
  logic rd_ok, wr_ok, intr_ok;
  logic wr_idle;

  assign wr_idle = (wr_outstanding == '0);

  assign rd_ok = !head_rdValid ||
                 (!c0TxAlmFull && !rd_full);
  assign wr_ok = !head_wrValid ||
                 (!c1TxAlmFull && !wr_full);
  // Interrupts must trail every write already in flight.
  assign intr_ok = !head_intrValid ||
                   (!c1TxAlmFull && wr_idle &&
                    !head_wrValid);

  assign deqTx = !reset && head_notEmpty &&
                 (state == RUN) && !drain_req &&
                 rd_ok && wr_ok && intr_ok;

  assign drain_done = (state == DRAIN) &&
                      (rd_outstanding == '0) &&
                      wr_idle;

  assign err_underflow = rd_uf | wr_uf;

  cci_mpf_prim_credit_counter #(
    .LIMIT (MAX_RD_OUT),
    .W     (CNT_BITS)
  ) rd_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (deqTx && head_rdValid),
    .dec       (c0_rsp_valid),
    .count     (rd_outstanding),
    .full      (rd_full),
    .underflow (rd_uf)
  );

  cci_mpf_prim_credit_counter #(
    .LIMIT (MAX_WR_OUT),
    .W     (CNT_BITS)
  ) wr_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (deqTx && head_wrValid),
    .dec       (c1_rsp_valid),
    .count     (wr_outstanding),
    .full      (wr_full),
    .underflow (wr_uf)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (drain_req)
          state_next = DRAIN;
        else if (head_notEmpty &&
                 head_intrValid && !intr_ok)
          state_next = INTR_WAIT;
      end
      INTR_WAIT: begin
        if (drain_req)    state_next = DRAIN;
        else if (wr_idle) state_next = RUN;
      end
      DRAIN: begin
        if (!drain_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_cci_mpf_shim_lockstep_deq_sched.sv
// Scoreboard bench for the lockstep dequeue scheduler.
// Directed scenarios followed by randomized traffic.
module tb_cci_mpf_shim_lockstep_deq_sched;

  localparam int RD_MAX = 2;
  localparam int WR_MAX = 6;
  localparam int CB = 3;

  logic clk = 1'b0;
  logic reset;
  logic head_notEmpty, head_rdValid;
  logic head_wrValid, head_intrValid;
  logic c0TxAlmFull, c1TxAlmFull;
  logic c0_rsp_valid, c1_rsp_valid;
  logic drain_req;
  logic deqTx, drain_done, err_underflow;
  logic [CB-1:0] rd_outstanding, wr_outstanding;

  always #5 clk = ~clk;

  cci_mpf_shim_lockstep_deq_sched #(
    .MAX_RD_OUT (RD_MAX),
    .MAX_WR_OUT (WR_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .head_notEmpty  (head_notEmpty),
    .head_rdValid   (head_rdValid),
    .head_wrValid   (head_wrValid),
    .head_intrValid (head_intrValid),
    .c0TxAlmFull    (c0TxAlmFull),
    .c1TxAlmFull    (c1TxAlmFull),
    .c0_rsp_valid   (c0_rsp_valid),
    .c1_rsp_valid   (c1_rsp_valid),
    .drain_req      (drain_req),
    .deqTx          (deqTx),
    .drain_done     (drain_done),
    .rd_outstanding (rd_outstanding),
    .wr_outstanding (wr_outstanding),
    .err_underflow  (err_underflow)
  );

  typedef struct {
    bit deq;
    bit done;
    int rd;
    int wr;
    bit err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit stim_done = 0;

  // Reference model: 0 issuing, 1 waiting on write acks, 2 draining
  int m_mode = 0;
  int m_rd = 0;
  int m_wr = 0;
  bit m_err = 0;

  task automatic step(input bit r, ne, rv, wv, iv,
                      a0, a1, p0, p1, dr);
    exp_t e;
    bit ok_r, ok_w, ok_i, deq;
    int n_mode;
    @(posedge clk);
    #1;
    reset = r;
    head_notEmpty = ne;
    head_rdValid = rv;
    head_wrValid = wv;
    head_intrValid = iv;
    c0TxAlmFull = a0;
    c1TxAlmFull = a1;
    c0_rsp_valid = p0;
    c1_rsp_valid = p1;
    drain_req = dr;
    ok_r = !rv || (!a0 && m_rd < RD_MAX);
    ok_w = !wv || (!a1 && m_wr < WR_MAX);
    ok_i = !iv || (!a1 && m_wr == 0 && !wv);
    deq = !r && ne && m_mode == 0 && !dr
          && ok_r && ok_w && ok_i;
    e.deq = deq;
    e.done = (m_mode == 2) && m_rd == 0 && m_wr == 0;
    e.rd = m_rd;
    e.wr = m_wr;
    e.err = m_err;
    q.push_back(e);
    if (r) begin
      m_mode = 0; m_rd = 0; m_wr = 0; m_err = 0;
    end else begin
      n_mode = m_mode;
      if (m_mode == 0) begin
        if (dr) n_mode = 2;
        else if (ne && iv && !ok_i) n_mode = 1;
      end else if (m_mode == 1) begin
        if (dr) n_mode = 2;
        else if (m_wr == 0) n_mode = 0;
      end else if (!dr) n_mode = 0;
      m_mode = n_mode;
      if ((deq && rv) != p0) begin
        if (p0 && m_rd == 0) m_err = 1;
        else if (p0) m_rd--;
        else if (m_rd < RD_MAX) m_rd++;
      end
      if ((deq && wv) != p1) begin
        if (p1 && m_wr == 0) m_err = 1;
        else if (p1) m_wr--;
        else if (m_wr < WR_MAX) m_wr++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("deqTx", int'(deqTx), int'(e.deq));
        chk("drain_done", int'(drain_done), int'(e.done));
        chk("rd_outstanding", int'(rd_outstanding), e.rd);
        chk("wr_outstanding", int'(wr_outstanding), e.wr);
        chk("err_underflow", int'(err_underflow), int'(e.err));
      end
    end
  end

  initial begin : stim
    bit ne, rv, wv, iv, dr;
    int k;
    reset = 1; head_notEmpty = 0; head_rdValid = 0;
    head_wrValid = 0; head_intrValid = 0;
    c0TxAlmFull = 0; c1TxAlmFull = 0;
    c0_rsp_valid = 0; c1_rsp_valid = 0; drain_req = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // single read issue and return
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // read credit limit
    repeat (3) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // no split on partial almost-full
    repeat (2) step(0, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // interrupt waits behind writes
    repeat (3) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // drain
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // underflow, then inc+dec at count 5
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    // randomized traffic
    dr = 0;
    for (int i = 0; i < 3000; i++) begin
      ne = ($urandom_range(0, 9) < 8);
      rv = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      wv = (k < 5);
      iv = (k == 9);
      if ($urandom_range(0, 39) == 0) dr = !dr;
      step(($urandom_range(0, 199) == 0), ne, rv, wv, iv,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0),
           (m_rd > 0) ? ($urandom_range(0, 2) == 0)
                      : ($urandom_range(0, 49) == 0),
           (m_wr > 0) ? ($urandom_range(0, 2) == 0)
                      : ($urandom_range(0, 49) == 0),
           dr);
    end
    idle(1);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
